// File: rtl/mat_rd_arbiter.sv
// Round-robin arbiter sharing one matrix-storage read port among NUM_REQ engines; one read in flight.
// Optional WAIT abort is enabled by defining ARB_TIMEOUT_EN (otherwise WAIT is unbounded).
module mat_rd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DIM_WIDTH   = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ID_WIDTH    = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_rd_en,
  input  logic [NUM_REQ-1:0]           req_slot,
  input  logic [NUM_REQ*DIM_WIDTH-1:0] req_row,
  input  logic [NUM_REQ*DIM_WIDTH-1:0] req_col,
  output logic [NUM_REQ-1:0]           req_elem_valid,
  output logic [DATA_WIDTH-1:0]        req_elem,
  output logic                         mem_rd_en,
  output logic                         mem_slot_idx,
  output logic [DIM_WIDTH-1:0]         mem_row_idx,
  output logic [DIM_WIDTH-1:0]         mem_col_idx,
  input  logic [DATA_WIDTH-1:0]        mem_rd_elem,
  input  logic                         mem_rd_valid,
  output logic                         busy,
  output logic [ID_WIDTH-1:0]          grant_id,
  output logic                         proto_err,
  output logic                         err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_WIDTH != $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_param_check
    $error("mat_rd_arbiter: unsupported parameter combination");
  end

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     pending_q, pending_d;
  logic [NUM_REQ-1:0]     slot_q, slot_d;
  logic [DIM_WIDTH-1:0]   row_q [NUM_REQ];
  logic [DIM_WIDTH-1:0]   row_d [NUM_REQ];
  logic [DIM_WIDTH-1:0]   col_q [NUM_REQ];
  logic [DIM_WIDTH-1:0]   col_d [NUM_REQ];
  logic [ID_WIDTH-1:0]    last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
  logic                   busy_q, busy_d;
  logic                   mem_rd_en_q, mem_rd_en_d;
  logic                   mem_slot_q, mem_slot_d;
  logic [DIM_WIDTH-1:0]   mem_row_q, mem_row_d;
  logic [DIM_WIDTH-1:0]   mem_col_q, mem_col_d;
  logic [DATA_WIDTH-1:0]  req_elem_q, req_elem_d;
  logic [NUM_REQ-1:0]     req_elem_valid_q, req_elem_valid_d;
  logic                   proto_err_q, proto_err_d;
  logic [ID_WIDTH-1:0]    cand;
  logic                   found;
  logic                   done;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_timeout_q, err_timeout_d;
`endif

  always_comb begin
    state_d          = state_q;
    pending_d        = pending_q;
    slot_d           = slot_q;
    row_d            = row_q;
    col_d            = col_q;
    last_grant_d     = last_grant_q;
    grant_id_d       = grant_id_q;
    busy_d           = busy_q;
    mem_rd_en_d      = 1'b0;
    mem_slot_d       = mem_slot_q;
    mem_row_d        = mem_row_q;
    mem_col_d        = mem_col_q;
    req_elem_d       = req_elem_q;
    req_elem_valid_d = '0;
    proto_err_d      = 1'b0;
    cand             = '0;
    found            = 1'b0;
    done             = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d        = tmo_cnt_q;
    err_timeout_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          // Scan upward from the engine after the last grantee, wrapping.
          for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_WIDTH'((int'(last_grant_q) + i) % NUM_REQ);
            if (!found && pending_q[cand]) begin
              found      = 1'b1;
              grant_id_d = cand;
            end
          end
          mem_rd_en_d = 1'b1;
          mem_slot_d  = slot_q[grant_id_d];
          mem_row_d   = row_q[grant_id_d];
          mem_col_d   = col_q[grant_id_d];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy_d  = 1'b1;
        state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (mem_rd_valid) begin
          req_elem_d = mem_rd_elem;
          done       = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          req_elem_d    = '0;
          err_timeout_d = 1'b1;
          done          = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
        if (done) begin
          req_elem_valid_d[grant_id_q] = 1'b1;
          last_grant_d                 = grant_id_q;
          busy_d                       = 1'b0;
          state_d                      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done) pending_d[grant_id_q] = 1'b0;
    // A request landing on the same edge its predecessor retires is accepted, not an overrun.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_rd_en[k]) begin
        if (pending_q[k] && !(done && grant_id_q == ID_WIDTH'(k))) begin
          proto_err_d = 1'b1;
        end else begin
          pending_d[k] = 1'b1;
          slot_d[k]    = req_slot[k];
          row_d[k]     = req_row[k*DIM_WIDTH +: DIM_WIDTH];
          col_d[k]     = req_col[k*DIM_WIDTH +: DIM_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      pending_q        <= '0;
      slot_q           <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        row_q[k] <= '0;
        col_q[k] <= '0;
      end
      last_grant_q     <= ID_WIDTH'(NUM_REQ - 1);
      grant_id_q       <= '0;
      busy_q           <= 1'b0;
      mem_rd_en_q      <= 1'b0;
      mem_slot_q       <= 1'b0;
      mem_row_q        <= '0;
      mem_col_q        <= '0;
      req_elem_q       <= '0;
      req_elem_valid_q <= '0;
      proto_err_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      slot_q           <= slot_d;
      row_q            <= row_d;
      col_q            <= col_d;
      last_grant_q     <= last_grant_d;
      grant_id_q       <= grant_id_d;
      busy_q           <= busy_d;
      mem_rd_en_q      <= mem_rd_en_d;
      mem_slot_q       <= mem_slot_d;
      mem_row_q        <= mem_row_d;
      mem_col_q        <= mem_col_d;
      req_elem_q       <= req_elem_d;
      req_elem_valid_q <= req_elem_valid_d;
      proto_err_q      <= proto_err_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign req_elem_valid = req_elem_valid_q;
  assign req_elem       = req_elem_q;
  assign mem_rd_en      = mem_rd_en_q;
  assign mem_slot_idx   = mem_slot_q;
  assign mem_row_idx    = mem_row_q;
  assign mem_col_idx    = mem_col_q;
  assign busy           = busy_q;
  assign grant_id       = grant_id_q;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_mat_rd_arbiter.sv
// Bench for mat_rd_arbiter: timeline model of grants/returns checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mat_rd_arbiter;
  localparam int NR = 4, DW = 3, XW = 8, IW = 2, TMO = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1;
  logic [NR-1:0] req_rd_en = '0, req_slot = '0;
  logic [NR*DW-1:0] req_row = '0, req_col = '0;
  logic [NR-1:0] req_elem_valid;
  logic [XW-1:0] req_elem, mem_rd_elem = '0;
  logic mem_rd_en, mem_slot_idx, mem_rd_valid = 1'b0, busy, proto_err, err_timeout;
  logic [DW-1:0] mem_row_idx, mem_col_idx;
  logic [IW-1:0] grant_id;

  mat_rd_arbiter #(.NUM_REQ(NR), .DIM_WIDTH(DW), .DATA_WIDTH(XW), .ID_WIDTH(IW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd_en(req_rd_en), .req_slot(req_slot), .req_row(req_row),
    .req_col(req_col), .req_elem_valid(req_elem_valid), .req_elem(req_elem), .mem_rd_en(mem_rd_en),
    .mem_slot_idx(mem_slot_idx), .mem_row_idx(mem_row_idx), .mem_col_idx(mem_col_idx),
    .mem_rd_elem(mem_rd_elem), .mem_rd_valid(mem_rd_valid), .busy(busy), .grant_id(grant_id),
    .proto_err(proto_err), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  bit chk_on = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Storage contents and a behavioural storage with configurable latency.
  logic [XW-1:0] mem_arr [2][8][8];
  int st_due[$], st_dat[$];
  int st_lat = 1;
  bit st_rand = 1'b0, st_silent = 1'b0;

  initial forever begin
    @(negedge clk);
    mem_rd_valid = 1'b0;
    mem_rd_elem  = XW'($urandom);
    if (st_due.size() != 0 && st_due[0] == cyc) begin
      mem_rd_valid = 1'b1;
      mem_rd_elem  = XW'(st_dat.pop_front());
      void'(st_due.pop_front());
    end
    if (mem_rd_en === 1'b1 && !st_silent) begin
      st_due.push_back(cyc + (st_rand ? int'($urandom_range(1, 3)) : st_lat));
      st_dat.push_back(int'(mem_arr[mem_slot_idx][mem_row_idx][mem_col_idx]));
    end
  end

  // Reference model: a read granted at edge 0 has mem_rd_en for one cycle, becomes busy
  // from edge 1, and may retire from edge 2 on (data) or at edge 1+TMO (abort).
  logic [NR-1:0] m_pend, m_slot, e_valid;
  logic [DW-1:0] m_row [NR], m_col [NR];
  int m_last, m_grant, m_age;
  bit m_out;
  logic [XW-1:0] e_elem;
  logic e_rden, e_mslot, e_busy, e_perr, e_tmo;
  logic [DW-1:0] e_mrow, e_mcol;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_slot = '0; m_last = NR - 1; m_grant = 0; m_age = 0; m_out = 1'b0;
      for (int k = 0; k < NR; k++) begin m_row[k] = '0; m_col[k] = '0; end
      e_valid = '0; e_elem = '0; e_rden = 0; e_mslot = 0; e_busy = 0; e_perr = 0; e_tmo = 0;
      e_mrow = '0; e_mcol = '0;
    end else begin : step
      logic [NR-1:0] pend0;
      bit ret;
      int g;
      pend0 = m_pend; ret = 1'b0; g = 0;
      e_rden = 0; e_valid = '0; e_perr = 0; e_tmo = 0;
      if (m_out) begin
        m_age++;
        if (m_age == 1) e_busy = 1'b1;
        else if (mem_rd_valid) begin
          ret = 1'b1;
          e_elem = mem_arr[m_slot[m_grant]][m_row[m_grant]][m_col[m_grant]];
        end else if (TMO_ON && m_age == 1 + TMO) begin
          ret = 1'b1; e_elem = '0; e_tmo = 1'b1;
        end
        if (ret) begin
          e_valid[m_grant] = 1'b1; m_last = m_grant; m_out = 1'b0; e_busy = 1'b0;
          m_pend[m_grant] = 1'b0;
        end
      end else if (pend0 != '0) begin
        for (int i = 1; i <= NR; i++) begin
          g = (m_last + i) % NR;
          if (pend0[g]) break;
        end
        m_grant = g; m_out = 1'b1; m_age = 0; e_rden = 1'b1;
        e_mslot = m_slot[g]; e_mrow = m_row[g]; e_mcol = m_col[g];
      end
      for (int k = 0; k < NR; k++) begin
        if (req_rd_en[k]) begin
          if (pend0[k] && !(ret && m_grant == k)) e_perr = 1'b1;
          else begin
            m_pend[k] = 1'b1; m_slot[k] = req_slot[k];
            m_row[k] = req_row[k*DW +: DW]; m_col[k] = req_col[k*DW +: DW];
          end
        end
      end
    end
  end

  // Per-cycle compare plus event logs for the directed checks.
  int rd_cyc[$], rd_addr[$], ret_id[$], ret_vec[$], ret_cyc[$], ret_dat[$];
  int n_perr = 0, n_tmo = 0, n_busy = 0;

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("req_elem_valid", 32'(req_elem_valid), 32'(e_valid));
      chk("req_elem", 32'(req_elem), 32'(e_elem));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rden));
      chk("mem_slot_idx", 32'(mem_slot_idx), 32'(e_mslot));
      chk("mem_row_idx", 32'(mem_row_idx), 32'(e_mrow));
      chk("mem_col_idx", 32'(mem_col_idx), 32'(e_mcol));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("grant_id", 32'(grant_id), 32'(m_grant));
      chk("proto_err", 32'(proto_err), 32'(e_perr));
      chk("err_timeout", 32'(err_timeout), 32'(e_tmo));
      if (mem_rd_en === 1'b1) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(int'({mem_slot_idx, mem_row_idx, mem_col_idx}));
      end
      for (int k = 0; k < NR; k++) if (req_elem_valid[k] === 1'b1) ret_id.push_back(k);
      if (req_elem_valid != '0) begin
        ret_vec.push_back(int'(req_elem_valid)); ret_cyc.push_back(cyc); ret_dat.push_back(int'(req_elem));
      end
      if (proto_err === 1'b1) n_perr++;
      if (err_timeout === 1'b1) n_tmo++;
      if (busy === 1'b1) n_busy++;
    end
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); ret_id.delete(); ret_vec.delete(); ret_cyc.delete(); ret_dat.delete();
    n_perr = 0; n_tmo = 0; n_busy = 0;
  endtask

  logic [NR-1:0] a_slot = '0;
  logic [DW-1:0] a_row [NR], a_col [NR];

  task automatic issue(input logic [NR-1:0] en, output int p0);
    @(negedge clk);
    p0 = cyc;
    req_rd_en = en;
    for (int k = 0; k < NR; k++) begin
      req_slot[k] = a_slot[k]; req_row[k*DW +: DW] = a_row[k]; req_col[k*DW +: DW] = a_col[k];
    end
    @(negedge clk);
    req_rd_en = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p0;

  initial begin
    for (int s = 0; s < 2; s++) for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++)
      mem_arr[s][r][c] = XW'($urandom);
    for (int k = 0; k < NR; k++) begin a_row[k] = '0; a_col[k] = '0; end
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    wait_cyc(2);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_grant", 32'(grant_id), 0);
    chk("reset_valid", 32'(req_elem_valid), 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Round robin from reset: all four at once, storage returns 0x10+id.
    for (int k = 0; k < NR; k++) begin
      a_slot[k] = 1'b0; a_row[k] = DW'(k); a_col[k] = DW'(k); mem_arr[0][k][k] = XW'(8'h10 + k);
    end
    clear_logs();
    issue(4'b1111, p0);
    wait_cyc(20);
    chk("rr_nret", ret_id.size(), 4);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rr_id%0d", k), qget(ret_id, k), k);
      chk($sformatf("rr_dat%0d", k), qget(ret_dat, k), 8'h10 + k);
    end
    for (int k = 0; k < 3; k++) chk($sformatf("rr_gap%0d", k), qget(rd_cyc, k + 1) - qget(rd_cyc, k), 3);

    // Single request from engine 2, 1-cycle storage.
    a_slot[2] = 1'b1; a_row[2] = 3'd3; a_col[2] = 3'd5; mem_arr[1][3][5] = 8'h5A;
    clear_logs();
    issue(4'b0100, p0);
    wait_cyc(10);
    chk("s1_nrd", rd_cyc.size(), 1);
    chk("s1_rd_lat", qget(rd_cyc, 0) - p0, 2);
    chk("s1_addr", qget(rd_addr, 0), 32'b1_011_101);
    chk("s1_vld", qget(ret_vec, 0), 4'b0100);
    chk("s1_dat", qget(ret_dat, 0), 8'h5A);
    chk("s1_lat", qget(ret_cyc, 0) - p0, 4);

    // Wrap: engine 3 served last, then 1 and 3 together.
    issue(4'b1000, p0);
    wait_cyc(8);
    clear_logs();
    issue(4'b1010, p0);
    wait_cyc(14);
    chk("wrap_n", ret_id.size(), 2);
    chk("wrap_first", qget(ret_id, 0), 1);
    chk("wrap_second", qget(ret_id, 1), 3);

    // Overrun: second pulse while the first is still pending.
    a_slot[0] = 1'b0; a_row[0] = 3'd1; a_col[0] = 3'd2;
    clear_logs();
    issue(4'b0001, p0);
    a_row[0] = 3'd6;
    issue(4'b0001, p0);
    wait_cyc(10);
    chk("ovr_perr", n_perr, 1);
    chk("ovr_nrd", rd_cyc.size(), 1);
    chk("ovr_row", (qget(rd_addr, 0) >> 3) & 7, 1);
    chk("ovr_nret", ret_id.size(), 1);

    // Reset during WAIT; the late storage return must be ignored.
    st_lat = 3;
    a_slot[1] = 1'b0; a_row[1] = 3'd7; a_col[1] = 3'd4;
    clear_logs();
    issue(4'b0010, p0);
    wait_cyc(2);
    chk("stale_busy", 32'(busy), 1);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(5);
    chk("stale_nret", ret_id.size(), 0);
    chk("stale_elem", 32'(req_elem), 0);
    chk("stale_busy_after", 32'(busy), 0);
    st_lat = 1;
    clear_logs();
    issue(4'b0010, p0);
    wait_cyc(8);
    chk("post_vld", qget(ret_vec, 0), 4'b0010);
    chk("post_dat", qget(ret_dat, 0), int'(mem_arr[0][7][4]));

    // Silent storage.
    st_silent = 1'b1;
    clear_logs();
    issue(4'b0001, p0);
    wait_cyc(30);
    if (TMO_ON) begin
      chk("tmo_wait_cycles", n_busy, TMO);
      chk("tmo_pulse", n_tmo, 1);
      chk("tmo_vld", qget(ret_vec, 0), 4'b0001);
      chk("tmo_dat", qget(ret_dat, 0), 0);
      chk("tmo_idle", 32'(busy), 0);
    end else begin
      chk("hang_busy", 32'(busy), 1);
      chk("hang_nret", ret_id.size(), 0);
      chk("hang_tmo", n_tmo, 0);
    end
    st_silent = 1'b0;
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(6);

    // Randomized traffic with random storage latency.
    st_rand = 1'b1;
    clear_logs();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        req_rd_en[k] = ($urandom_range(0, 5) == 0);
        req_slot[k] = 1'($urandom);
        req_row[k*DW +: DW] = DW'($urandom);
        req_col[k*DW +: DW] = DW'($urandom);
      end
    end
    @(negedge clk);
    req_rd_en = '0;
    wait_cyc(30);
    chk("rnd_activity", 32'(ret_id.size() > 300), 1);
    chk("rnd_overruns_seen", 32'(n_perr > 0), 1);
    chk("rnd_drained", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mat_rd_arbiter.md
Name: mat_rd_arbiter

Overview:
- Shares the single matrix-storage read port among NUM_REQ compute engines (mult, add, transpose, display).
- Each engine keeps its own rd_en-pulse / rd_elem_valid protocol and needs no change.
- Latches each pulsed request, grants round-robin, allows one outstanding storage read, and routes the returned element to its owner.
- Sits between the engines and the storage block.

Parameters:
NUM_REQ, 4, number of requesting engines (2..8)
DIM_WIDTH, 3, row/col index width
DATA_WIDTH, 8, element width
ID_WIDTH, 2, grant id width, equal to clog2(NUM_REQ)
TIMEOUT_CYC, 15, max WAIT cycles before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_rd_en  in  NUM_REQ  per-engine one-cycle read request pulse
req_slot  in  NUM_REQ  per-engine slot index
req_row  in  NUM_REQ*DIM_WIDTH  packed row indices; engine k uses bits [k*DIM_WIDTH +: DIM_WIDTH]
req_col  in  NUM_REQ*DIM_WIDTH  packed col indices, same packing
req_elem_valid  out  NUM_REQ  one-hot one-cycle data-return pulse
req_elem  out  DATA_WIDTH  returned element, broadcast to all engines
mem_rd_en  out  1  storage read pulse
mem_slot_idx  out  1  storage slot
mem_row_idx  out  DIM_WIDTH  storage row
mem_col_idx  out  DIM_WIDTH  storage col
mem_rd_elem  in  DATA_WIDTH  storage data
mem_rd_valid  in  1  storage data valid
busy  out  1  high while a read is outstanding (WAIT)
grant_id  out  ID_WIDTH  id of last/current grantee
proto_err  out  1  one-cycle pulse on request overrun
err_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- All outputs reset to 0. pending, latched addresses and state clear. last_grant resets to NUM_REQ-1, so engine 0 has first priority.
- Capture: req_rd_en[k]=1 sets pending[k] and latches slot/row/col[k] at the next edge.
- Overrun: req_rd_en[k] while pending[k] is already set (and not being cleared that cycle) → request dropped, original address kept, proto_err pulses.
- Same-cycle clear and new request for k: the new request is latched and pending[k] stays 1.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, no pending: stay in IDLE.
- IDLE, pending nonzero: pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap. Register g into grant_id and go to ISSUE.
- ISSUE: mem_rd_en=1 for exactly one cycle. mem_slot_idx/row/col come from the latched entry g and hold until the next ISSUE. Next state is WAIT; busy=1.
- WAIT, mem_rd_valid=1: req_elem<=mem_rd_elem, req_elem_valid[g]<=1 for one cycle, pending[g] clears, last_grant<=g, busy<=0, next state IDLE.
- WAIT, mem_rd_valid=0: stay in WAIT.
- Latency, 1-cycle storage, no contention: pulse at edge t → pending t+1 → ISSUE t+2 (mem_rd_en high) → mem_rd_valid t+3 → req_elem_valid t+4.
- Storage read issues back-to-back every 3 cycles under full load.
- mem_rd_valid outside WAIT is ignored; no output change.
- Requests arriving during ISSUE/WAIT only set pending; arbitration happens only in IDLE.
- Fairness: with all engines requesting continuously, grant order is 0,1,2,3,0,…
- Reset mid-WAIT clears everything; a later stale mem_rd_valid is ignored.
- req_elem holds its last value between returns.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a counter clears on entering WAIT and increments each WAIT cycle without mem_rd_valid. On reaching TIMEOUT_CYC:
  - req_elem<=0 and req_elem_valid[g] pulses;
  - err_timeout pulses and pending[g] clears;
  - last_grant<=g; next state IDLE.
  - The engine is released, never hung.
- Undefined: WAIT lasts indefinitely; err_timeout is tied to 0; no counter is synthesized.

Test Plan:
- Single request, 1-cycle storage: engine 2 pulses (slot1,row3,col5); storage returns 0x5A → mem_rd_en one cycle with 1/3/5, then req_elem_valid=4'b0100, req_elem=0x5A, 4 cycles after the pulse.
- Round-robin: all 4 engines pulse in the same cycle, storage returns 0x10+id → grants 0,1,2,3 in order, each engine receives its own value once, mem_rd_en pulses 3 cycles apart.
- Wrap fairness: last_grant=3, engines 1 and 3 pending → engine 1 granted first, then 3.
- Overrun: engine 0 pulses row1, then row6 while row1 still pending → proto_err pulses once; storage is read at row1 only.
- Stale/reset: reset asserted during WAIT, then mem_rd_valid arrives → all outputs 0, no req_elem_valid; a new request afterwards completes normally.
- With ARB_TIMEOUT_EN and storage silent → exactly 15 WAIT cycles, then err_timeout and req_elem_valid[g] with req_elem=0, return to IDLE. Without the macro, busy stays 1.
